// File: rtl/multicycle_flag_adder_if.sv
// Operand/result handshake bundle for multicycle_flag_adder.
// The producer/consumer side uses master; the adder uses slave.
interface multicycle_flag_adder_if #(
   parameter int N = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] num1;
   logic [N-1:0] num2;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sum;
   logic         carry_flag;
   logic         zero_flag;
   logic         overflow_flag;
   logic         parity_flag;
   logic         sign_flag;

   modport master (
      output in_valid, num1, num2, sub, out_ready,
      input  in_ready, out_valid, sum, carry_flag, zero_flag,
             overflow_flag, parity_flag, sign_flag
   );

   modport slave (
      input  in_valid, num1, num2, sub, out_ready,
      output in_ready, out_valid, sum, carry_flag, zero_flag,
             overflow_flag, parity_flag, sign_flag
   );
endinterface

// File: rtl/multicycle_flag_adder.sv
// Sequential add/subtract with C/Z/V/P/S flags, CHUNK bits per cycle through one slice adder.
// Define ADDER_SAT_EN to clamp the result to the signed range on overflow.
module multicycle_flag_adder #(
   parameter int N     = 16,
   parameter int CHUNK = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   multicycle_flag_adder_if.slave bus
);
   localparam int NCH = N / CHUNK;
   localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic            in_ready, out_valid, accept, last_slice;
   logic [N-1:0]    a_q, b_q, work_q, work_d, result;
   logic            carry_q;
   logic [KW-1:0]   k_q;
   logic [N-1:0]    sum_q;
   logic            c_flag_q, z_flag_q, v_flag_q, p_flag_q, s_flag_q;
   int              base;
   logic [CHUNK-1:0] a_slice, b_slice, slice_sum;
   logic [CHUNK:0]  slice_full;
   logic            carry_out, carry_into_msb, overflow;

   assign accept     = bus.in_valid && in_ready;
   assign last_slice = (state_q == CALC) && (k_q == K_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) state_d = CALC;
         end
         CALC: if (last_slice) state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Slice adder; the carry into the slice MSB is recovered from the MSB sum bit,
   // which also holds when CHUNK is 1 and the incoming carry is the MSB carry-in.
   always_comb begin
      base           = int'(k_q) * CHUNK;
      a_slice        = a_q[base +: CHUNK];
      b_slice        = b_q[base +: CHUNK];
      slice_full     = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
      slice_sum      = slice_full[CHUNK-1:0];
      carry_out      = slice_full[CHUNK];
      carry_into_msb = a_slice[CHUNK-1] ^ b_slice[CHUNK-1] ^ slice_sum[CHUNK-1];
      overflow       = carry_into_msb ^ carry_out;
      work_d         = work_q;
      work_d[base +: CHUNK] = slice_sum;
      result         = work_d;
`ifdef ADDER_SAT_EN
      if (overflow) result = a_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`else
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         work_q   <= '0;
         carry_q  <= 1'b0;
         k_q      <= '0;
         sum_q    <= '0;
         c_flag_q <= 1'b0;
         z_flag_q <= 1'b0;
         v_flag_q <= 1'b0;
         p_flag_q <= 1'b0;
         s_flag_q <= 1'b0;
      end else if (accept) begin
         a_q     <= bus.num1;
         b_q     <= bus.sub ? ~bus.num2 : bus.num2;
         carry_q <= bus.sub;
         k_q     <= '0;
         work_q  <= '0;
      end else if (state_q == CALC) begin
         work_q  <= work_d;
         carry_q <= carry_out;
         k_q     <= k_q + 1'b1;
         if (last_slice) begin
            sum_q    <= result;
            c_flag_q <= carry_out;
            v_flag_q <= overflow;
            z_flag_q <= (result == '0);
            p_flag_q <= ~^result;
            s_flag_q <= result[N-1];
         end
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = out_valid;
   assign bus.sum           = sum_q;
   assign bus.carry_flag    = c_flag_q;
   assign bus.zero_flag     = z_flag_q;
   assign bus.overflow_flag = v_flag_q;
   assign bus.parity_flag   = p_flag_q;
   assign bus.sign_flag     = s_flag_q;
endmodule
